decoder_scan_n: RTL and testbench

DECODER_SCAN_N -- requirements
Module: decoder_scan_n

---
 rtl/decoder_scan_n.sv | 95 +++++++++
 tb/tb_decoder_scan_n.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2**N one-hot decoder.
// - Direct mode decodes inp every cycle.
// - Auto-scan mode starts at inp, then steps through every slot. Each slot is
//   held for DWELL cycles, and wrap pulses when the index rolls over to 0.
// Build option: define DECODER_SCAN_ACTIVE_LOW_EN for an active-low out bus
// (selected bit 0, idle value all ones). idx, wrap and timing are the same in both builds.
module decoder_scan_n #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [N-1:0]      inp,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W         = 1 << N;
  localparam logic [7:0]  DwellLast = 8'(DWELL - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0] OutIdle = '1;
`else
  localparam logic [W-1:0] OutIdle = '0;
`endif

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e         state_q;
  logic [W-1:0]   out_q;
  logic [N-1:0]   idx_q;
  logic           wrap_q;
  logic [7:0]     dwell_q;
  logic [N-1:0]   idx_inc;

  // One-hot decode. XOR with the idle pattern flips polarity for the active-low build.
  function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
    logic [W-1:0] hot;
    hot      = '0;
    hot[sel] = 1'b1;
    return hot ^ OutIdle;
  endfunction

  // Natural N-bit rollover gives the modulo-2**N step.
  assign idx_inc = idx_q + N'(1);

  // State machine with registered outputs. The priority order is rst, then enable,
  // then mode, then the scan step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= OutIdle;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else if (!enable) begin
      // idx holds its last value while idle.
      state_q <= StIdle;
      out_q   <= OutIdle;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else if (!mode) begin
      state_q <= StDirect;
      out_q   <= decode(inp);
      idx_q   <= inp;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else if (state_q != StScan) begin
      // Entering scan: load the start slot. wrap stays low even if inp is 0.
      state_q <= StScan;
      out_q   <= decode(inp);
      idx_q   <= inp;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else if (dwell_q == DwellLast) begin
      // Slot is done: advance. wrap is set only on the step from the top slot.
      out_q   <= decode(idx_inc);
      idx_q   <= idx_inc;
      wrap_q  <= &idx_q;
      dwell_q <= '0;
    end else begin
      // Hold the current slot. inp is ignored while scanning.
      wrap_q  <= 1'b0;
      dwell_q <= dwell_q + 8'd1;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n.
// - The stimulus side drives inputs on the falling edge.
// - A reference model works from elapsed-time arithmetic and pushes the expected
//   response into a queue.
// - The monitor pops and compares just after each rising edge.
module tb_decoder_scan_n;

  localparam int unsigned N     = 3;
  localparam int unsigned DWELL = 4;
  localparam int unsigned W     = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         mode;
  logic [N-1:0] inp;
  logic [W-1:0] out;
  logic [N-1:0] idx;
  logic         wrap;

  decoder_scan_n #(
    .N     (N),
    .DWELL (DWELL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .inp    (inp),
    .out    (out),
    .idx    (idx),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [N-1:0] idx;
    logic         wrap;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model. Scan position comes from the start slot and the cycles spent in scan.
  int unsigned m_state = 0;  // 0 idle, 1 direct, 2 scan
  int unsigned m_idx   = 0;
  int unsigned m_start = 0;
  int unsigned m_k     = 0;

  function automatic logic [W-1:0] exp_out(input bit active, input int unsigned i);
    logic [W-1:0] v;
    logic [W-1:0] one;
    one = 1;
    v   = active ? (one << i) : '0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic m, input logic [N-1:0] s,
                     input string tag);
    exp_t x;
    bit   w;
    @(negedge clk);
    rst    = r;
    enable = e;
    mode   = m;
    inp    = s;
    w      = 1'b0;
    if (r) begin
      m_state = 0;
      m_idx   = 0;
    end else if (!e) begin
      m_state = 0;
    end else if (!m) begin
      m_state = 1;
      m_idx   = s;
    end else if (m_state != 2) begin
      m_state = 2;
      m_start = s;
      m_k     = 0;
      m_idx   = s;
    end else begin
      m_k++;
      m_idx = (m_start + m_k / DWELL) % W;
      w     = (m_k % DWELL == 0) && (m_idx == 0);
    end
    x.out  = exp_out(m_state != 0, m_idx);
    x.idx  = m_idx[N-1:0];
    x.wrap = w;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  // Monitor: one registered response per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
          n_bad++;
          $display("FAIL %s @%0t: got out=%h idx=%0d wrap=%0b, want out=%h idx=%0d wrap=%0b",
                   e.tag, $time, out, idx, wrap, e.out, e.idx, e.wrap);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    mode   = 1'b1;
    inp    = '0;

    // Reset with enable and mode high.
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 3'd5, "reset");

    // Direct sweep.
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'b0, 3'(i), "direct_sweep");

    // Scan from 6 through the wrap. inp noise is ignored.
    cyc(1'b0, 1'b1, 1'b1, 3'd6, "scan_entry");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 3'($urandom), "scan_run");

    // Scan entry with inp=0 must not raise wrap.
    cyc(1'b0, 1'b1, 1'b0, 3'd3, "direct_pre0");
    cyc(1'b0, 1'b1, 1'b1, 3'd0, "scan_entry0");
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 3'd7, "scan_hold0");

    // Abort in the 2nd dwell cycle of slot 2, then re-enter at 1.
    cyc(1'b0, 1'b1, 1'b0, 3'd0, "direct_pre");
    cyc(1'b0, 1'b1, 1'b1, 3'd2, "scan_entry2");
    cyc(1'b0, 1'b1, 1'b1, 3'd4, "scan_dwell2");
    cyc(1'b0, 1'b1, 1'b0, 3'd5, "abort_direct");
    cyc(1'b0, 1'b1, 1'b1, 3'd1, "reentry");
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 3'd3, "reentry_run");

    // Enable drop holds idx. Then reset mid-dwell.
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 3'd3, "enable_drop");
    cyc(1'b0, 1'b1, 1'b1, 3'd5, "scan_entry5");
    cyc(1'b0, 1'b1, 1'b1, 3'd0, "scan_mid");
    cyc(1'b1, 1'b1, 1'b1, 3'd0, "rst_mid_dwell");
    cyc(1'b0, 1'b1, 1'b1, 3'd4, "post_rst_scan");
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 3'd1, "post_rst_run");

    // Random traffic. Mode is sticky so that scans run long enough to wrap.
    begin
      logic m;
      m = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(47) == 0) m = ~m;
        cyc(1'($urandom_range(59) == 0), 1'($urandom_range(11) != 0), m, 3'($urandom),
            "random");
      end
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
